// File: rtl/ctrl_pkg.sv
// Shared definitions for the hardwired control sequencer: state encodings,
// opcodes, ALU codes, IR field positions and the registered strobe bundle.
package ctrl_pkg;

    typedef logic [3:0] state_t;

    localparam state_t ST_RST       = 4'd0;
    localparam state_t ST_T0        = 4'd1;
    localparam state_t ST_T1        = 4'd2;
    localparam state_t ST_T2        = 4'd3;
    localparam state_t ST_T3        = 4'd4;
    localparam state_t ST_T4        = 4'd5;
    localparam state_t ST_T5        = 4'd6;
    localparam state_t ST_T6        = 4'd7;
    localparam state_t ST_HALT      = 4'd8;
    localparam state_t ST_WAIT_STEP = 4'd9;

    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_MUL  = 5'b01001;
    localparam logic [4:0] OP_DIV  = 5'b01010;
    localparam logic [4:0] OP_NOP  = 5'b10000;
    localparam logic [4:0] OP_HALT = 5'b10001;

    localparam logic [4:0] ALU_ADD = 5'b00000;
    localparam logic [4:0] ALU_SUB = 5'b00001;
    localparam logic [4:0] ALU_MUL = 5'b00010;
    localparam logic [4:0] ALU_DIV = 5'b00011;
    localparam logic [4:0] ALU_AND = 5'b00100;
    localparam logic [4:0] ALU_OR  = 5'b00101;

    localparam int IR_OPC_MSB = 31;
    localparam int IR_OPC_LSB = 27;
    localparam int IR_RA_MSB  = 26;
    localparam int IR_RA_LSB  = 23;
    localparam int IR_RB_MSB  = 22;
    localparam int IR_RB_LSB  = 19;
    localparam int IR_RC_MSB  = 18;
    localparam int IR_RC_LSB  = 15;

    typedef struct packed {
        logic       pc_out;
        logic       zlo_out;
        logic       zhi_out;
        logic       mdr_out;
        logic       r_out;
        logic [3:0] r_out_sel;
        logic       mar_in;
        logic       pc_in;
        logic       mdr_in;
        logic       ir_in;
        logic       y_in;
        logic       z_in;
        logic       hi_in;
        logic       lo_in;
        logic       r_in;
        logic [3:0] r_in_sel;
        logic       inc_pc;
        logic       read;
        logic [4:0] control;
        logic       run;
    } ctrl_out_t;

    function automatic logic [4:0] alu_code(input logic [4:0] opcode);
        logic [4:0] code;
        case (opcode)
            OP_ADD:  code = ALU_ADD;
            OP_SUB:  code = ALU_SUB;
            OP_AND:  code = ALU_AND;
            OP_OR:   code = ALU_OR;
            OP_MUL:  code = ALU_MUL;
            OP_DIV:  code = ALU_DIV;
            default: code = ALU_ADD;
        endcase
        return code;
    endfunction

    // Idle bundle: every strobe low, machine still running.
    function automatic ctrl_out_t idle_outputs();
        ctrl_out_t o;
        o     = '0;
        o.run = 1'b1;
        return o;
    endfunction

endpackage

// File: rtl/ir_decoder.sv
// Combinational instruction classifier: splits IR into its register fields
// and instruction class flags; unknown opcodes classify as NOP.
module ir_decoder
    import ctrl_pkg::*;
(
    input  logic [16:0] ir_hi,
    output logic        is_alu3,
    output logic        is_muldiv,
    output logic        is_nop,
    output logic        is_halt,
    output logic [3:0]  ra,
    output logic [3:0]  rb,
    output logic [3:0]  rc,
    output logic [4:0]  alu_ctl
);

    logic [31:0] ir_s;
    logic [4:0]  opcode_s;

    assign ir_s     = {ir_hi, 15'd0};
    assign opcode_s = ir_s[IR_OPC_MSB:IR_OPC_LSB];
    assign ra       = ir_s[IR_RA_MSB:IR_RA_LSB];
    assign rb       = ir_s[IR_RB_MSB:IR_RB_LSB];
    assign rc       = ir_s[IR_RC_MSB:IR_RC_LSB];
    assign alu_ctl  = alu_code(opcode_s);

    // Opcode class decode.
    always_comb begin
        is_alu3   = 1'b0;
        is_muldiv = 1'b0;
        is_nop    = 1'b0;
        is_halt   = 1'b0;
        case (opcode_s)
            OP_ADD, OP_SUB, OP_AND, OP_OR: is_alu3   = 1'b1;
            OP_MUL, OP_DIV:                is_muldiv = 1'b1;
            OP_HALT:                       is_halt   = 1'b1;
            default:                       is_nop    = 1'b1;
        endcase
    end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired fetch/decode/execute sequencer with registered Moore strobes.
// Optional macro CTRL_SINGLE_STEP_EN adds a Step input and a WAIT_STEP state.
module control_sequencer
    import ctrl_pkg::*;
#(
    parameter int MEM_WAIT_MAX = 15
) (
    input  logic        Clock,
    input  logic        Clear,
    input  logic [31:0] IR,
    input  logic        Mem_Ready,
`ifdef CTRL_SINGLE_STEP_EN
    input  logic        Step,
`endif
    output logic        PC_Out,
    output logic        ZLO_Out,
    output logic        ZHI_Out,
    output logic        MDR_Out,
    output logic        R_Out,
    output logic [3:0]  R_Out_Sel,
    output logic        MAR_In,
    output logic        PC_In,
    output logic        MDR_In,
    output logic        IR_In,
    output logic        Y_In,
    output logic        Z_In,
    output logic        HI_In,
    output logic        LO_In,
    output logic        R_In,
    output logic [3:0]  R_In_Sel,
    output logic        IncPC,
    output logic        Read,
    output logic [4:0]  CONTROL,
    output logic        Run,
    output logic        Mem_Timeout
);

    localparam int CNT_W = $clog2(MEM_WAIT_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MEM_WAIT_MAX);

`ifdef CTRL_SINGLE_STEP_EN
    localparam state_t ST_DONE = ST_WAIT_STEP;
`else
    localparam state_t ST_DONE = ST_T0;
`endif

    state_t           state_r, state_nxt_s;
    ctrl_out_t        out_r, out_nxt_s;
    logic [CNT_W-1:0] wait_cnt_r, wait_cnt_nxt_s;
    logic             mem_timeout_r;

    logic       is_alu3_s, is_muldiv_s, is_nop_s, is_halt_s;
    logic [3:0] ra_s, rb_s, rc_s;
    logic [4:0] alu_ctl_s;
    logic       ir_unused_s;

    assign ir_unused_s = ^IR[14:0];

    ir_decoder u_ir_decoder (
        .ir_hi     (IR[31:15]),
        .is_alu3   (is_alu3_s),
        .is_muldiv (is_muldiv_s),
        .is_nop    (is_nop_s),
        .is_halt   (is_halt_s),
        .ra        (ra_s),
        .rb        (rb_s),
        .rc        (rc_s),
        .alu_ctl   (alu_ctl_s)
    );

    // Next-state sequencing.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_RST:  state_nxt_s = ST_T0;
            ST_T0:   state_nxt_s = ST_T1;
            ST_T1: begin
                if (Mem_Ready) state_nxt_s = ST_T2;
                else           state_nxt_s = ST_T1;
            end
            ST_T2:   state_nxt_s = ST_T3;
            ST_T3: begin
                if (is_halt_s)     state_nxt_s = ST_HALT;
                else if (is_nop_s) state_nxt_s = ST_DONE;
                else               state_nxt_s = ST_T4;
            end
            ST_T4:   state_nxt_s = ST_T5;
            ST_T5: begin
                if (is_muldiv_s) state_nxt_s = ST_T6;
                else             state_nxt_s = ST_DONE;
            end
            ST_T6:   state_nxt_s = ST_DONE;
            ST_HALT: state_nxt_s = ST_HALT;
`ifdef CTRL_SINGLE_STEP_EN
            ST_WAIT_STEP: begin
                if (Step) state_nxt_s = ST_T0;
                else      state_nxt_s = ST_WAIT_STEP;
            end
`endif
            default: state_nxt_s = ST_RST;
        endcase
    end

    // Strobes for the state being entered; T3 strobes use IR as seen on that edge.
    always_comb begin
        out_nxt_s = idle_outputs();
        case (state_nxt_s)
            ST_T0: begin
                out_nxt_s.pc_out = 1'b1;
                out_nxt_s.mar_in = 1'b1;
                out_nxt_s.inc_pc = 1'b1;
                out_nxt_s.z_in   = 1'b1;
            end
            ST_T1: begin
                out_nxt_s.zlo_out = 1'b1;
                out_nxt_s.pc_in   = (state_r != ST_T1);
                out_nxt_s.read    = 1'b1;
                out_nxt_s.mdr_in  = 1'b1;
            end
            ST_T2: begin
                out_nxt_s.mdr_out = 1'b1;
                out_nxt_s.ir_in   = 1'b1;
            end
            ST_T3: begin
                if (!is_nop_s && !is_halt_s) begin
                    out_nxt_s.r_out     = 1'b1;
                    out_nxt_s.r_out_sel = rb_s;
                    out_nxt_s.y_in      = 1'b1;
                end else begin
                    out_nxt_s.r_out = 1'b0;
                end
            end
            ST_T4: begin
                out_nxt_s.r_out     = 1'b1;
                out_nxt_s.r_out_sel = rc_s;
                out_nxt_s.z_in      = 1'b1;
                out_nxt_s.control   = alu_ctl_s;
            end
            ST_T5: begin
                out_nxt_s.zlo_out = 1'b1;
                out_nxt_s.control = alu_ctl_s;
                if (is_muldiv_s) begin
                    out_nxt_s.lo_in = 1'b1;
                end else if (is_alu3_s) begin
                    out_nxt_s.r_in     = 1'b1;
                    out_nxt_s.r_in_sel = ra_s;
                end else begin
                    out_nxt_s.r_in = 1'b0;
                end
            end
            ST_T6: begin
                out_nxt_s.zhi_out = 1'b1;
                out_nxt_s.hi_in   = 1'b1;
                out_nxt_s.control = alu_ctl_s;
            end
            ST_HALT: out_nxt_s.run = 1'b0;
            default: out_nxt_s.run = 1'b1;
        endcase
    end

    // Memory wait counter: counts T1 cycles without Mem_Ready, saturating at the limit.
    always_comb begin
        if (state_r == ST_T1 && !Mem_Ready) begin
            if (wait_cnt_r == CNT_MAX) wait_cnt_nxt_s = wait_cnt_r;
            else                       wait_cnt_nxt_s = wait_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            wait_cnt_nxt_s = '0;
        end
    end

    // State, strobe and timeout registers.
    always_ff @(posedge Clock or posedge Clear) begin
        if (Clear) begin
            state_r       <= ST_RST;
            out_r         <= idle_outputs();
            wait_cnt_r    <= '0;
            mem_timeout_r <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            out_r      <= out_nxt_s;
            wait_cnt_r <= wait_cnt_nxt_s;
            if (wait_cnt_nxt_s == CNT_MAX) mem_timeout_r <= 1'b1;
            else                           mem_timeout_r <= mem_timeout_r;
        end
    end

    assign PC_Out      = out_r.pc_out;
    assign ZLO_Out     = out_r.zlo_out;
    assign ZHI_Out     = out_r.zhi_out;
    assign MDR_Out     = out_r.mdr_out;
    assign R_Out       = out_r.r_out;
    assign R_Out_Sel   = out_r.r_out_sel;
    assign MAR_In      = out_r.mar_in;
    assign PC_In       = out_r.pc_in;
    assign MDR_In      = out_r.mdr_in;
    assign IR_In       = out_r.ir_in;
    assign Y_In        = out_r.y_in;
    assign Z_In        = out_r.z_in;
    assign HI_In       = out_r.hi_in;
    assign LO_In       = out_r.lo_in;
    assign R_In        = out_r.r_in;
    assign R_In_Sel    = out_r.r_in_sel;
    assign IncPC       = out_r.inc_pc;
    assign Read        = out_r.read;
    assign CONTROL     = out_r.control;
    assign Run         = out_r.run;
    assign Mem_Timeout = mem_timeout_r;

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: fetch timing, ALU/MUL sequences,
// memory wait and timeout, HALT, undefined opcode and mid-instruction Clear.
module tb_control_sequencer;

    logic        Clock = 1'b0;
    logic        Clear;
    logic [31:0] IR;
    logic        Mem_Ready;
    logic        PC_Out, ZLO_Out, ZHI_Out, MDR_Out, R_Out;
    logic [3:0]  R_Out_Sel, R_In_Sel;
    logic        MAR_In, PC_In, MDR_In, IR_In, Y_In, Z_In, HI_In, LO_In, R_In;
    logic        IncPC, Read, Run, Mem_Timeout;
    logic [4:0]  CONTROL;

    int n_cmp = 0;
    int n_err = 0;

    // Strobe order: PC_Out ZLO_Out ZHI_Out MDR_Out R_Out MAR_In PC_In MDR_In
    //               IR_In Y_In Z_In HI_In LO_In R_In IncPC Read
    logic [15:0] strobes;
    assign strobes = {PC_Out, ZLO_Out, ZHI_Out, MDR_Out, R_Out, MAR_In, PC_In, MDR_In,
                      IR_In, Y_In, Z_In, HI_In, LO_In, R_In, IncPC, Read};

    localparam logic [15:0] S_NONE   = 16'h0000;
    localparam logic [15:0] S_T0     = 16'h8422;
    localparam logic [15:0] S_T1_1ST = 16'h4301;
    localparam logic [15:0] S_T1     = 16'h4101;
    localparam logic [15:0] S_T2     = 16'h1080;
    localparam logic [15:0] S_T3     = 16'h0840;
    localparam logic [15:0] S_T4     = 16'h0820;
    localparam logic [15:0] S_T5_ALU = 16'h4004;
    localparam logic [15:0] S_T5_MD  = 16'h4008;
    localparam logic [15:0] S_T6     = 16'h2010;

    localparam logic [31:0] IR_ADD  = 32'h19920000;
    localparam logic [31:0] IR_MUL  = 32'h4A920000;
    localparam logic [31:0] IR_NOP  = 32'h80000000;
    localparam logic [31:0] IR_HALT = 32'h88000000;
    localparam logic [31:0] IR_UNDF = 32'hF8000000;

    control_sequencer #(.MEM_WAIT_MAX(15)) dut (
        .Clock       (Clock),
        .Clear       (Clear),
        .IR          (IR),
        .Mem_Ready   (Mem_Ready),
        .PC_Out      (PC_Out),
        .ZLO_Out     (ZLO_Out),
        .ZHI_Out     (ZHI_Out),
        .MDR_Out     (MDR_Out),
        .R_Out       (R_Out),
        .R_Out_Sel   (R_Out_Sel),
        .MAR_In      (MAR_In),
        .PC_In       (PC_In),
        .MDR_In      (MDR_In),
        .IR_In       (IR_In),
        .Y_In        (Y_In),
        .Z_In        (Z_In),
        .HI_In       (HI_In),
        .LO_In       (LO_In),
        .R_In        (R_In),
        .R_In_Sel    (R_In_Sel),
        .IncPC       (IncPC),
        .Read        (Read),
        .CONTROL     (CONTROL),
        .Run         (Run),
        .Mem_Timeout (Mem_Timeout)
    );

    always #5 Clock = ~Clock;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Wait for the next falling edge and check the whole strobe bundle.
    task automatic expect_cycle(input string tag, input logic [15:0] s_exp, input logic run_exp,
                                input logic [4:0] ctl_exp, input logic [3:0] osel,
                                input logic [3:0] isel);
        @(negedge Clock);
        check_eq({tag, ".strobes"}, {16'd0, strobes}, {16'd0, s_exp});
        check_eq({tag, ".run"}, {31'd0, Run}, {31'd0, run_exp});
        check_eq({tag, ".control"}, {27'd0, CONTROL}, {27'd0, ctl_exp});
        check_eq({tag, ".onebus"}, {31'd0, ($countones({PC_Out, ZLO_Out, ZHI_Out, MDR_Out, R_Out}) <= 1)},
                 32'd1);
        if (s_exp[11]) check_eq({tag, ".rout_sel"}, {28'd0, R_Out_Sel}, {28'd0, osel});
        if (s_exp[2])  check_eq({tag, ".rin_sel"}, {28'd0, R_In_Sel}, {28'd0, isel});
    endtask

    // T0 of a new instruction, then load its IR and run a zero-wait fetch.
    task automatic fetch(input string tag, input logic [31:0] ir);
        expect_cycle({tag, ":T0"}, S_T0, 1'b1, 5'd0, 4'd0, 4'd0);
        IR = ir;
        Mem_Ready = 1'b1;
        expect_cycle({tag, ":T1"}, S_T1_1ST, 1'b1, 5'd0, 4'd0, 4'd0);
        expect_cycle({tag, ":T2"}, S_T2, 1'b1, 5'd0, 4'd0, 4'd0);
    endtask

    initial begin
        Clear = 1'b1;
        IR = IR_ADD;
        Mem_Ready = 1'b1;
        repeat (2) @(negedge Clock);
        check_eq("rst.strobes", {16'd0, strobes}, 32'd0);
        check_eq("rst.run", {31'd0, Run}, 32'd1);
        check_eq("rst.timeout", {31'd0, Mem_Timeout}, 32'd0);
        check_eq("rst.control", {27'd0, CONTROL}, 32'd0);
        Clear = 1'b0;

        // ADD r3 = r2 + r4: six cycles
        fetch("add", IR_ADD);
        expect_cycle("add:T3", S_T3, 1'b1, 5'd0, 4'd2, 4'd0);
        expect_cycle("add:T4", S_T4, 1'b1, 5'd0, 4'd4, 4'd0);
        expect_cycle("add:T5", S_T5_ALU, 1'b1, 5'd0, 4'd0, 4'd3);

        // MUL r5, r2, r4: seven cycles
        fetch("mul", IR_MUL);
        expect_cycle("mul:T3", S_T3, 1'b1, 5'd0, 4'd2, 4'd0);
        expect_cycle("mul:T4", S_T4, 1'b1, 5'b00010, 4'd4, 4'd0);
        expect_cycle("mul:T5", S_T5_MD, 1'b1, 5'b00010, 4'd0, 4'd0);
        expect_cycle("mul:T6", S_T6, 1'b1, 5'b00010, 4'd0, 4'd0);

        // ADD aborted by Clear in the middle of T4
        fetch("addclr", IR_ADD);
        expect_cycle("addclr:T3", S_T3, 1'b1, 5'd0, 4'd2, 4'd0);
        expect_cycle("addclr:T4", S_T4, 1'b1, 5'd0, 4'd4, 4'd0);
        #2 Clear = 1'b1;
        #1;
        check_eq("clr.strobes", {16'd0, strobes}, 32'd0);
        check_eq("clr.run", {31'd0, Run}, 32'd1);
        check_eq("clr.control", {27'd0, CONTROL}, 32'd0);
        @(negedge Clock);
        Clear = 1'b0;

        // Undefined opcode behaves as NOP: four cycles
        fetch("undef", IR_UNDF);
        expect_cycle("undef:T3", S_NONE, 1'b1, 5'd0, 4'd0, 4'd0);

        // NOP with Mem_Ready low for three T1 edges
        expect_cycle("wait3:T0", S_T0, 1'b1, 5'd0, 4'd0, 4'd0);
        IR = IR_NOP;
        Mem_Ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            expect_cycle($sformatf("wait3:T1.%0d", i), (i == 0) ? S_T1_1ST : S_T1, 1'b1, 5'd0,
                         4'd0, 4'd0);
            if (i == 3) Mem_Ready = 1'b1;
        end
        expect_cycle("wait3:T2", S_T2, 1'b1, 5'd0, 4'd0, 4'd0);
        check_eq("wait3.timeout", {31'd0, Mem_Timeout}, 32'd0);
        expect_cycle("wait3:T3", S_NONE, 1'b1, 5'd0, 4'd0, 4'd0);

        // Mem_Ready low for sixteen T1 edges: timeout from T1 cycle 15
        expect_cycle("tout:T0", S_T0, 1'b1, 5'd0, 4'd0, 4'd0);
        Mem_Ready = 1'b0;
        for (int i = 0; i < 17; i++) begin
            expect_cycle($sformatf("tout:T1.%0d", i), (i == 0) ? S_T1_1ST : S_T1, 1'b1, 5'd0,
                         4'd0, 4'd0);
            check_eq($sformatf("tout.flag%0d", i), {31'd0, Mem_Timeout}, {31'd0, (i >= 15)});
            if (i == 16) Mem_Ready = 1'b1;
        end
        expect_cycle("tout:T2", S_T2, 1'b1, 5'd0, 4'd0, 4'd0);
        expect_cycle("tout:T3", S_NONE, 1'b1, 5'd0, 4'd0, 4'd0);

        // HALT: Run drops after T3 and everything stays quiet
        fetch("halt", IR_HALT);
        expect_cycle("halt:T3", S_NONE, 1'b1, 5'd0, 4'd0, 4'd0);
        for (int i = 0; i < 5; i++)
            expect_cycle($sformatf("halt:H%0d", i), S_NONE, 1'b0, 5'd0, 4'd0, 4'd0);
        check_eq("halt.timeout_sticky", {31'd0, Mem_Timeout}, 32'd1);

        // Clear leaves HALT and drops the timeout flag
        Clear = 1'b1;
        #1;
        check_eq("unhalt.run", {31'd0, Run}, 32'd1);
        check_eq("unhalt.timeout", {31'd0, Mem_Timeout}, 32'd0);
        @(negedge Clock);
        Clear = 1'b0;
        expect_cycle("unhalt:T0", S_T0, 1'b1, 5'd0, 4'd0, 4'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
